// File: rtl/pgm_pkg.sv
// pgm_pkg: shared FSM encoding, arbitration modes and default parameters
package pgm_pkg;
    typedef enum logic [1:0] {S_IDLE, S_ARB, S_WAIT} state_t;
    localparam int ARB_RR          = 0;
    localparam int ARB_STRICT      = 1;
    localparam int DEF_NCH         = 8;
    localparam int DEF_LEN_W       = 12;
    localparam int DEF_TB_W        = 16;
    localparam int DEF_USEDW_W     = 7;
    localparam int DEF_FIFO_THRESH = 96;
    localparam int DEF_ARB_MODE    = ARB_RR;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin or strict-priority channel picker
module rr_arbiter import pgm_pkg::*; #(
    parameter int NCH      = DEF_NCH,
    parameter int ARB_MODE = DEF_ARB_MODE
) (
    input  logic [NCH-1:0]         elig,
    input  logic [$clog2(NCH)-1:0] ptr,
    output logic [NCH-1:0]         onehot,
    output logic [$clog2(NCH)-1:0] idx
);
    localparam int IW = $clog2(NCH);
    logic [IW-1:0] j;
    // scan farthest candidate first so the nearest eligible one is the last written
    always_comb begin
        idx = '0;
        j   = '0;
        for (int k = NCH; k >= 1; k--) begin
            j = (ARB_MODE == ARB_STRICT) ? IW'(k - 1) : IW'((int'(ptr) + k) % NCH);
            if (elig[j]) idx = j;
        end
        onehot = (|elig) ? (NCH'(1) << idx) : '0;
    end
endmodule

// File: rtl/traffic_sched.sv
// traffic_sched: token-bucket shaped multi-channel packet grant scheduler
module traffic_sched import pgm_pkg::*; #(
    parameter int NCH         = DEF_NCH,
    parameter int LEN_W       = DEF_LEN_W,
    parameter int TB_W        = DEF_TB_W,
    parameter int USEDW_W     = DEF_USEDW_W,
    parameter int FIFO_THRESH = DEF_FIFO_THRESH,
    parameter int ARB_MODE    = DEF_ARB_MODE
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_test_start,
    input  logic                   i_cnt_rst,
    input  logic                   i_tick,
    input  logic [NCH*LEN_W-1:0]   iv_pkt_len,
    input  logic [NCH*TB_W-1:0]    iv_tb_size,
    input  logic [NCH*TB_W-1:0]    iv_tb_rate,
    input  logic [NCH-1:0]         iv_gate,
    input  logic [USEDW_W-1:0]     iv_fifo_usedw,
    input  logic                   i_pkt_done,
    output logic [NCH-1:0]         ov_selected,
    output logic [$clog2(NCH)-1:0] ov_sel_idx,
    output logic                   o_busy,
    output logic [NCH*32-1:0]      ov_grant_cnt
);
    localparam int IW = $clog2(NCH);
    localparam int CW = TB_W + 1;
    state_t         state, state_nxt;
    logic [NCH-1:0] elig, arb_onehot;
    logic [IW-1:0]  arb_idx, ptr;
    logic           grant;

    assign grant  = state == S_ARB && i_test_start && |elig && int'(iv_fifo_usedw) < FIFO_THRESH;
    assign o_busy = state == S_WAIT;

    rr_arbiter #(.NCH(NCH), .ARB_MODE(ARB_MODE)) u_arb (
        .elig   (elig),
        .ptr    (ptr),
        .onehot (arb_onehot),
        .idx    (arb_idx)
    );

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [CW-1:0] tok, size, rate, sum, topped;
        logic [31:0]   len, gcnt;
        assign size   = {1'b0, iv_tb_size[i*TB_W +: TB_W]};
        assign rate   = {1'b0, iv_tb_rate[i*TB_W +: TB_W]};
        assign len    = 32'(iv_pkt_len[i*LEN_W +: LEN_W]);
        assign sum    = tok + rate;
        assign topped = i_tick && sum > size ? size : i_tick ? sum : tok;
        assign elig[i] = 32'(tok) >= len && len != 0 && iv_gate[i];
        assign ov_grant_cnt[i*32 +: 32] = gcnt;
        // token bucket: cleared when stopped, filled on start, refilled on tick, drained on grant
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) tok <= '0;
            else if (!i_test_start) tok <= '0;
            else if (state == S_IDLE) tok <= size;
            else if (grant && arb_onehot[i]) tok <= 32'(topped) >= len ? CW'(32'(topped) - len) : '0;
            else tok <= topped;
        // grant counter; clear wins over a coincident grant
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) gcnt <= '0;
            else if (i_cnt_rst) gcnt <= '0;
            else if (grant && arb_onehot[i]) gcnt <= gcnt + 32'd1;
    end

    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= S_IDLE;
        else state <= state_nxt;

    // next state: stop overrides everything, pkt_done only matters in WAIT
    always_comb begin
        state_nxt = !i_test_start ? S_IDLE :
                    state == S_IDLE ? S_ARB :
                    state == S_ARB ? (grant ? S_WAIT : S_ARB) :
                    (i_pkt_done ? S_ARB : S_WAIT);
    end

    // registered one-hot grant pulse, held grant index and round-robin pointer
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ov_selected <= '0;
            ov_sel_idx  <= '0;
            ptr         <= IW'(NCH - 1);
        end else begin
            ov_selected <= grant ? arb_onehot : '0;
            if (grant) begin
                ov_sel_idx <= arb_idx;
                ptr        <= arb_idx;
            end
        end
endmodule

// File: tb/tb_traffic_sched.sv
// tb_traffic_sched: directed checks of round-robin and strict-priority schedulers
module tb_traffic_sched;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         test_start = 1'b0, cnt_rst = 1'b0, tick = 1'b0, pkt_done = 1'b0;
    logic [95:0]  pkt_len = '0;
    logic [127:0] tb_size = '0, tb_rate = '0;
    logic [7:0]   gate = '0;
    logic [6:0]   usedw = '0;
    logic [7:0]   sel_a, sel_b;
    logic [2:0]   idx_a, idx_b;
    logic         busy_a, busy_b;
    logic [255:0] gc_a, gc_b;
    int           checks = 0, errors = 0;

    always #5 clk = ~clk;

    traffic_sched dut_a (
        .clk(clk), .rst_n(rst_n), .i_test_start(test_start), .i_cnt_rst(cnt_rst), .i_tick(tick),
        .iv_pkt_len(pkt_len), .iv_tb_size(tb_size), .iv_tb_rate(tb_rate), .iv_gate(gate),
        .iv_fifo_usedw(usedw), .i_pkt_done(pkt_done), .ov_selected(sel_a), .ov_sel_idx(idx_a),
        .o_busy(busy_a), .ov_grant_cnt(gc_a)
    );

    traffic_sched #(.ARB_MODE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_test_start(test_start), .i_cnt_rst(cnt_rst), .i_tick(tick),
        .iv_pkt_len(pkt_len), .iv_tb_size(tb_size), .iv_tb_rate(tb_rate), .iv_gate(gate),
        .iv_fifo_usedw(usedw), .i_pkt_done(pkt_done), .ov_selected(sel_b), .ov_sel_idx(idx_b),
        .o_busy(busy_b), .ov_grant_cnt(gc_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic done_pulse();
        pkt_done = 1'b1;
        step();
        pkt_done = 1'b0;
    endtask

    task automatic tick_pulse();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    initial begin
        for (int c = 0; c < 8; c++) begin
            tb_size[c*16 +: 16] = 16'd1000;
            tb_rate[c*16 +: 16] = 16'd100;
        end
        pkt_len[11:0] = 12'd500;
        gate = 8'hff;
        step();
        check("rst_sel", sel_a, 0);
        check("rst_idx", idx_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_gcnt", gc_a[31:0], 0);
        rst_n = 1'b1;
        step();
        check("no_grant_after_release", sel_a, 0);

        test_start = 1'b1;
        step();
        check("start_no_grant", sel_a, 0);
        check("start_load", dut_a.g_ch[0].tok, 1000);
        step();
        check("g1_sel", sel_a, 8'h01);
        check("g1_busy", busy_a, 1);
        check("g1_tok", dut_a.g_ch[0].tok, 500);
        step(3);
        check("g1_pulse_one_cycle", sel_a, 0);
        done_pulse();
        check("done_to_arb", busy_a, 0);
        step();
        check("g2_sel", sel_a, 8'h01);
        check("g2_tok", dut_a.g_ch[0].tok, 0);
        check("g2_cnt", gc_a[31:0], 2);
        done_pulse();
        for (int t = 0; t < 4; t++) begin
            tick_pulse();
            step();
        end
        check("4tick_tok", dut_a.g_ch[0].tok, 400);
        check("4tick_no_grant", gc_a[31:0], 2);
        check("4tick_idle_busy", busy_a, 0);
        tick_pulse();
        check("5tick_tok", dut_a.g_ch[0].tok, 500);
        check("5tick_sel_wait", sel_a, 0);
        step();
        check("g3_sel", sel_a, 8'h01);
        check("g3_cnt", gc_a[31:0], 3);
        check("g3_cnt_b", gc_b[31:0], 3);

        gate[0] = 1'b0;
        tb_rate[15:0] = 16'd950;
        done_pulse();
        tick_pulse();
        check("prefill_950", dut_a.g_ch[0].tok, 950);
        gate[0] = 1'b1;
        tb_rate[15:0] = 16'd100;
        tick_pulse();
        check("tick_grant_sel", sel_a, 8'h01);
        check("tick_grant_tok", dut_a.g_ch[0].tok, 500);
        gate[0] = 1'b0;
        done_pulse();

        usedw = 7'd96;
        gate[0] = 1'b1;
        step(3);
        check("fifo96_busy", busy_a, 0);
        check("fifo96_cnt", gc_a[31:0], 4);
        usedw = 7'd95;
        step();
        check("fifo95_sel", sel_a, 8'h01);
        check("fifo95_cnt", gc_a[31:0], 5);
        gate[0] = 1'b0;
        usedw = 7'd0;
        done_pulse();

        tb_rate[15:0] = 16'd1000;
        tick_pulse();
        check("refill_tok", dut_a.g_ch[0].tok, 1000);
        gate[0] = 1'b1;
        cnt_rst = 1'b1;
        step();
        cnt_rst = 1'b0;
        check("cntrst_sel", sel_a, 8'h01);
        check("cntrst_cnt_a", gc_a[31:0], 0);
        check("cntrst_cnt_b", gc_b[31:0], 0);
        gate[0] = 1'b0;
        done_pulse();
        gate[0] = 1'b1;
        step();
        check("pre_stop_busy", busy_a, 1);
        test_start = 1'b0;
        step();
        check("stop_busy", busy_a, 0);
        check("stop_tok1", dut_a.g_ch[1].tok, 0);
        check("stop_sel", sel_a, 0);
        done_pulse();
        step();
        check("late_done_busy", busy_a, 0);
        check("late_done_sel", sel_a, 0);

        rst_n = 1'b0;
        step();
        check("rerst_cnt", gc_a[31:0], 0);
        check("rerst_idx", idx_a, 0);
        for (int c = 0; c < 8; c++) begin
            pkt_len[c*12 +: 12] = 12'd100;
            tb_rate[c*16 +: 16] = 16'd100;
        end
        gate = 8'hff;
        rst_n = 1'b1;
        step();
        test_start = 1'b1;
        step();
        check("rr_first_cycle", sel_a, 0);
        step();
        for (int k = 0; k < 9; k++) begin
            check($sformatf("rr_idx%0d", k), idx_a, k % 8);
            check($sformatf("rr_sel%0d", k), sel_a, 8'h01 << (k % 8));
            check($sformatf("sp_idx%0d", k), idx_b, 0);
            check($sformatf("sp_sel%0d", k), sel_b, 8'h01);
            if (k < 8) begin
                done_pulse();
                step();
            end
        end

        for (int c = 0; c < 8; c++) pkt_len[c*12 +: 12] = (c >= 2 && c <= 4) ? 12'd100 : 12'd0;
        gate[3] = 1'b0;
        done_pulse();
        step();
        check("gate_rr_idx2", idx_a, 2);
        check("gate_rr_sel2", sel_a, 8'h04);
        check("gate_sp_idx2", idx_b, 2);
        done_pulse();
        step();
        check("gate_rr_idx4", idx_a, 4);
        check("gate_rr_sel4", sel_a, 8'h10);
        check("gate_sp_again2", idx_b, 2);
        check("cnt_a_ch0", gc_a[31:0], 2);
        check("cnt_a_ch2", gc_a[95:64], 2);
        check("cnt_a_ch3", gc_a[127:96], 1);
        check("cnt_a_ch4", gc_a[159:128], 2);
        check("cnt_b_ch0", gc_b[31:0], 9);
        check("cnt_b_ch2", gc_b[95:64], 2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/traffic_sched.md
TRAFFIC_SCHED -- requirements
Module: traffic_sched

Interface
REQ-001 SHALL have parameter NCH, default 8, meaning number of traffic channels (2..16).
REQ-002 SHALL have parameter LEN_W, default 12, meaning packet-length width in bytes.
REQ-003 SHALL have parameter TB_W, default 16, meaning token-bucket size and rate width.
REQ-004 SHALL have parameter USEDW_W, default 7, meaning downstream FIFO used-word width.
REQ-005 SHALL have parameter FIFO_THRESH, default 96, meaning the FIFO level at or above which no grant is issued.
REQ-006 SHALL have parameter ARB_MODE, default 0, meaning arbitration mode: 0 = round-robin, 1 = strict priority with lowest index highest.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-008 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-009 SHALL have port i_test_start, input, 1 bit: level; high enables generation.
REQ-010 SHALL have port i_cnt_rst, input, 1 bit: synchronous clear of grant counters.
REQ-011 SHALL have port i_tick, input, 1 bit: refill strobe for the token buckets.
REQ-012 SHALL have port iv_pkt_len, input, NCH*LEN_W bits: per-channel packet length; channel i occupies slice i.
REQ-013 SHALL have ports iv_tb_size and iv_tb_rate, input, NCH*TB_W bits each: per-channel bucket depth and tokens added per tick.
REQ-014 SHALL have port iv_gate, input, NCH bits: per-channel gate-open from the gate control list.
REQ-015 SHALL have port iv_fifo_usedw, input, USEDW_W bits: downstream FIFO fill level.
REQ-016 SHALL have port i_pkt_done, input, 1 bit: one-cycle pulse when the granted packet has been fully emitted.
REQ-017 SHALL have port ov_selected, output, NCH bits: one-hot grant pulse.
REQ-018 SHALL have port ov_sel_idx, output, clog2(NCH) bits: binary index of the current grant.
REQ-019 SHALL have port o_busy, output, 1 bit: high while a granted packet is outstanding.
REQ-020 SHALL have port ov_grant_cnt, output, NCH*32 bits: per-channel grant counters.

Function
REQ-021 SHALL keep one token counter per channel, TB_W+1 bits wide, so that additions never overflow before saturation.
REQ-022 SHALL hold all counters at 0 while i_test_start is low.
REQ-023 SHALL load every counter with its tb_size on the first cycle i_test_start is high.
REQ-024 On each i_tick cycle, SHALL set each counter to min(count + rate, size).
REQ-025 SHALL treat channel i as eligible when count_i >= len_i, len_i != 0, and iv_gate[i] = 1.
REQ-026 SHALL use a three-state FSM: IDLE, ARB, WAIT.
- IDLE to ARB: when i_test_start = 1.
- ARB to WAIT: on a grant.
- WAIT to ARB: on i_pkt_done.
- Any state to IDLE: when i_test_start = 0.
REQ-027 In ARB, SHALL issue a grant only when at least one channel is eligible and iv_fifo_usedw < FIFO_THRESH.
REQ-028 On a grant, ov_selected SHALL be a registered one-cycle one-hot pulse, one cycle after eligibility is sampled; ov_sel_idx SHALL hold the index until the next grant.
REQ-029 The granted channel's counter SHALL be decremented by len in the grant cycle.
- If i_tick coincides with the grant, the result SHALL be min(count + rate, size) - len, computed without underflow.
REQ-030 Round-robin mode SHALL search from (last_grant + 1) mod NCH, wrapping around; the pointer SHALL reset to NCH-1 so that channel 0 is checked first.
REQ-031 Strict mode SHALL grant the lowest eligible index.
REQ-032 o_busy SHALL be 1 exactly while in WAIT.
- An i_pkt_done arriving outside WAIT SHALL be ignored.
REQ-033 A grant SHALL increment that channel's 32-bit counter, which wraps at 2^32.
REQ-034 i_cnt_rst SHALL clear all grant counters.
- If i_cnt_rst and a grant occur in the same cycle, the counter SHALL be cleared and the grant not counted.
REQ-035 If i_test_start falls mid-packet, SHALL go to IDLE next cycle, deassert o_busy, and issue no further pulses; counters SHALL be cleared.
REQ-036 Configuration inputs SHALL be sampled live, with no shadowing.

Reset
REQ-037 On rst_n low, asynchronously:
- FSM = IDLE.
- ov_selected = 0, ov_sel_idx = 0, o_busy = 0.
- All token counters = 0, all grant counters = 0.
- Round-robin pointer = NCH-1.
REQ-038 Reset deassertion SHALL be synchronised externally; the block SHALL issue no grant in the first cycle after release.

Structure
REQ-039 The shared package pgm_pkg SHALL hold the FSM state encoding, the ARB_MODE constants, and the default parameter values.
REQ-040 Arbitration SHALL be a sub-module rr_arbiter (parameters NCH and ARB_MODE; eligible vector and pointer in; one-hot and index out; combinational).
- All registers stay in traffic_sched.

Verification
REQ-041 Single channel, NCH=8, size=1000, rate=100, len=500, gate all 1, a tick every 10 cycles, pkt_done 5 cycles after each grant:
- Expect grants on channel 0 only.
- Counter goes 1000 -> 500 -> 0; the next grant comes only after 5 ticks.
REQ-042 Round-robin with all channels eligible: grant order 0,1,...,7,0.
- With ARB_MODE=1: grant order 0,0,0.
REQ-043 iv_fifo_usedw=96:
- No grant.
- Dropping usedw to 95 yields a grant one cycle later.
REQ-044 Tick coincident with grant, count=950, rate=100, size=1000, len=500: resulting counter = 500.
REQ-045 Mid-operation events:
- i_test_start dropped in WAIT: o_busy = 0 next cycle, counters = 0, a later pkt_done is ignored.
- i_cnt_rst coincident with a grant: that channel's counter reads 0.
REQ-046 Gate closed on channel 3 while 2 and 4 are eligible: round-robin after a grant to 2 skips to 4.
